// File: rtl/top_level_pkg.sv
// Shared constants, FSM state type and the SECDED (16,11) encoder.
package top_level_pkg;

    localparam int MSG_COUNT = 15;
    localparam int SRC_BASE  = 0;
    localparam int DST_BASE  = 30;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        START = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } state_t;

    function automatic logic [15:0] hamming_enc(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/top_level_if.sv
// Single-port memory bus between the program FSM and its data memory.
interface top_level_if;
    import top_level_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/top_level_data_mem.sv
// 256 x 8 data memory: combinational read, synchronous write, no reset.
module data_mem
    import top_level_pkg::*;
(
    input  logic       clk,
    top_level_if.slave bus
);

    logic [DATA_W-1:0] core [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            core[bus.addr] <= bus.wdata;
        end
    end

    assign bus.rdata = core[bus.addr];

endmodule

// File: rtl/top_level.sv
// Program-driven datapath; progID=1 Hamming-encodes 15 messages in dm1.
// Optional TRACE_EN macro enables simulation-only trace output.
module top_level
    import top_level_pkg::*;
#(
    parameter int progID = 1
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    top_level_if mbus ();

    data_mem dm1 (
        .clk (clk),
        .bus (mbus)
    );

    state_t      state, nstate;
    logic [3:0]  i, i_n;
    logic [7:0]  lo;
    logic [2:0]  hi;
    logic [11:1] d;
    logic [15:0] cw;
    logic [7:0]  pair;
    logic        unused_hi;

    assign d         = {hi, lo};
    assign cw        = hamming_enc(d);
    assign pair      = {3'b000, i, 1'b0};
    assign unused_hi = ^mbus.rdata[7:3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= START;
            i     <= '0;
            lo    <= '0;
            hi    <= '0;
            done  <= 1'b0;
        end else begin
            state <= nstate;
            i     <= i_n;
            done  <= (nstate == FIN);
            if (state == RD_LO) lo <= mbus.rdata;
            if (state == RD_HI) hi <= mbus.rdata[2:0];
        end
    end

    always_comb begin
        nstate     = state;
        i_n        = i;
        mbus.addr  = '0;
        mbus.wdata = '0;
        mbus.we    = 1'b0;
        unique case (state)
            START: nstate = (progID == 1) ? RD_LO : FIN;
            RD_LO: begin
                mbus.addr = 8'(SRC_BASE) + pair;
                nstate    = RD_HI;
            end
            RD_HI: begin
                mbus.addr = 8'(SRC_BASE) + pair + 8'd1;
                nstate    = WR_LO;
            end
            WR_LO: begin
                mbus.addr  = 8'(DST_BASE) + pair;
                mbus.wdata = cw[7:0];
                mbus.we    = 1'b1;
                nstate     = WR_HI;
            end
            WR_HI: begin
                mbus.addr  = 8'(DST_BASE) + pair + 8'd1;
                mbus.wdata = cw[15:8];
                mbus.we    = 1'b1;
                if (i == 4'(MSG_COUNT - 1)) begin
                    nstate = FIN;
                end else begin
                    i_n    = i + 4'd1;
                    nstate = RD_LO;
                end
            end
            FIN:     nstate = FIN;
            default: nstate = START;
        endcase
    end

`ifdef TRACE_EN
    always @(posedge clk) begin
        if (!reset && state == WR_HI)
            $display("trace i=%0d d=%b cw=%b", i, d, cw);
        if (!reset && state != FIN && nstate == FIN)
            $display("program done");
    end
`endif

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: preloads dm1.core, checks codewords and timing.
module tb_top_level;
    import top_level_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done, done0;

    int n_cmp = 0;
    int n_bad = 0;
    int bad_wr = 0;
    int cyc;
    logic d0_first;
    logic [7:0] src [0:29];

    always #5 clk = ~clk;

    top_level #(.progID(1)) dut  (.clk(clk), .reset(reset), .done(done));
    top_level #(.progID(0)) dut0 (.clk(clk), .reset(reset), .done(done0));

    top_level_if mon ();
    assign mon.addr  = dut.mbus.addr;
    assign mon.wdata = dut.mbus.wdata;
    assign mon.we    = dut.mbus.we;
    assign mon.rdata = dut.mbus.rdata;

    always @(posedge clk)
        if (mon.we && (mon.addr < 8'd30 || mon.addr > 8'd59))
            bad_wr++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Positional Hamming: data in non-power-of-two slots 3..15, parity at 1,2,4,8.
    function automatic logic [15:0] model_enc(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic p;
        c = '0;
        k = 0;
        for (int pos = 3; pos < 16; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) == 1) p = p ^ c[pos];
            c[1 << b] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic preload(input logic [7:0] fill);
        for (int k = 0; k < 30; k++) dut.dm1.core[k] = src[k];
        for (int k = 30; k < 60; k++) dut.dm1.core[k] = fill;
        dut.dm1.core[60]  = 8'h3C;
        dut.dm1.core[255] = 8'hC3;
    endtask

    task automatic run_prog(output int cycles);
        @(negedge clk);
        reset = 1'b0;
        cycles = 0;
        while (!done && cycles < 80) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) d0_first = done0;
        end
    endtask

    task automatic check_out(input string tag);
        logic [15:0] got, exp;
        for (int m = 0; m < 15; m++) begin
            exp = model_enc({src[2*m+1][2:0], src[2*m]});
            got = {dut.dm1.core[31+2*m], dut.dm1.core[30+2*m]};
            chk($sformatf("%s_cw%0d", tag, m), got, exp);
        end
        for (int k = 0; k < 30; k++)
            chk($sformatf("%s_src%0d", tag, k), dut.dm1.core[k], src[k]);
        chk({tag, "_core60"}, dut.dm1.core[60], 8'h3C);
        chk({tag, "_core255"}, dut.dm1.core[255], 8'hC3);
        chk({tag, "_done"}, done, 1'b1);
    endtask

    task automatic load_table();
        logic [10:0] tbl [0:11];
        logic [10:0] v;
        tbl = '{11'h555, 11'h2AA, 11'h123, 11'h7FE, 11'h0F0, 11'h70F,
                11'h3C3, 11'h1A5, 11'h6B9, 11'h044, 11'h7FF, 11'h2D1};
        src[0] = 8'h01; src[1] = 8'h00;
        src[2] = 8'h00; src[3] = 8'h04;
        src[4] = 8'hFF; src[5] = 8'hFF;
        for (int m = 0; m < 12; m++) begin
            v = tbl[m];
            src[6+2*m] = v[7:0];
            src[7+2*m] = {(m[0] ? 5'b10101 : 5'b00000), v[10:8]};
        end
    endtask

    initial begin
        dut0.dm1.core[30] = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_state", dut.state, START);
        chk("rst_i", dut.i, 4'd0);
        chk("rst_lo", dut.lo, 8'h00);

        // all-zero messages
        for (int k = 0; k < 30; k++) src[k] = 8'h00;
        preload(8'hA5);
        run_prog(cyc);
        chk("zero_latency", cyc, 61);
        chk("prog0_done_first", d0_first, 1'b1);
        for (int m = 0; m < 15; m++)
            chk($sformatf("zero_cw%0d", m),
                {dut.dm1.core[31+2*m], dut.dm1.core[30+2*m]}, 16'h0000);
        check_out("zero");

        // directed + table messages
        reset = 1'b1;
        @(posedge clk);
        load_table();
        preload(8'hA5);
        run_prog(cyc);
        chk("tbl_latency", cyc, 61);
        chk("d001_lo", dut.dm1.core[30], 8'h0F);
        chk("d001_hi", dut.dm1.core[31], 8'h00);
        chk("d400_lo", dut.dm1.core[32], 8'h17);
        chk("d400_hi", dut.dm1.core[33], 8'h81);
        chk("junk_lo", dut.dm1.core[34], 8'hFF);
        chk("junk_hi", dut.dm1.core[35], 8'hFF);
        check_out("tbl");

        // async reset while done is high
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_done_drop", done, 1'b0);

        // abort mid-run, then restart
        @(posedge clk);
        preload(8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_done", done, 1'b0);
        chk("abort_i", dut.i, 4'd0);
        chk("abort_state", dut.state, START);
        chk("abort_kept_lo", dut.dm1.core[30], 8'h0F);
        chk("abort_untouched", dut.dm1.core[59], 8'h00);
        @(posedge clk);
        run_prog(cyc);
        chk("restart_latency", cyc, 61);
        check_out("restart");

        chk("prog0_nowrite", dut0.dm1.core[30], 8'h5A);
        chk("prog0_done", done0, 1'b1);
        chk("wr_range", bad_wr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Program-driven datapath block whose progID=1 program performs Hamming SECDED (16,11) encoding of 15 messages held in its internal data memory.
- Processing starts when reset is released; completion is signalled on done.
- Sits at the top of the processor hierarchy and owns instance dm1 (data memory, array core).
- The bench preloads and reads core directly by hierarchical reference.

Parameters:
- progID, 1, program select. 1 = Hamming encode. Any other value: no memory writes, done asserts on the first clock edge after reset release.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  one clock; reset is asynchronous and active-high. A reset pulse also acts as the start request.
- done  output  1  high when the program is finished; held until next reset.

Behaviour:
- Memory: instance name dm1, array core, 256 x 8 bits. Combinational read, synchronous write, one access per cycle.
- Reset never clears core; preloaded contents must survive reset.
- Reset values: done=0, FSM=START, message index i=0, internal latches 0.
- Message i (i=0..14): d[11:1] = {core[2i+1][2:0], core[2i][7:0]}. Bits core[2i+1][7:3] are ignored.
- Parity bits:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1]^p8^p4^p2^p1
- Codeword[15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
- Codeword placement: core[30+2i] = codeword[7:0], core[31+2i] = codeword[15:8].
- FSM states: START, RD_LO, RD_HI, WR_LO, WR_HI, FIN.
  - START -> RD_LO on the first rising edge after reset deasserts.
  - RD_LO: latch core[2i].
  - RD_HI: latch core[2i+1].
  - WR_LO: write the low byte.
  - WR_HI: write the high byte; if i=14 go to FIN, else i++ and go to RD_LO.
  - FIN: done=1, no further writes, stays in FIN until reset.
- Timing: 4 cycles per message, 60 processing cycles total. done rises within 62 clock edges of reset release.
- Only core[30..59] is ever written; core[0..29] and core[60..255] stay unchanged.
- Reset asserted mid-operation: abort immediately and drop done to 0. Bytes already written remain. Restart from i=0 on release; re-encoding gives identical results because the source bytes are untouched.
- done is glitch-free (registered).

Optional Feature:
- Macro TRACE_EN.
- Defined: simulation-only $display of i, the input d[11:1] and the codeword (binary) on each WR_HI, plus a "program done" message on entry to FIN. No effect on synthesized logic.
- Undefined: no display statements compiled; behaviour otherwise identical.

Decomposition:
- Package top_level_pkg:
  - constants MSG_COUNT=15, SRC_BASE=0, DST_BASE=30, ADDR_W=8, DATA_W=8
  - FSM state enum
  - pure function hamming_enc(logic [11:1]) returning logic [15:0]
- One sub-module: data_mem (256x8, combinational read, synchronous write), instantiated as dm1 with array named core. Both hierarchical names are fixed.

Test Plan:
- All-zero messages: core[0..29]=0x00 -> every codeword 0x0000, done asserted, core[60]/core[255] unchanged.
- d=0x001 (core[2i]=0x01, core[2i+1]=0x00) -> core[30+2i]=0x0F, core[31+2i]=0x00.
- d=0x400 (core[2i+1]=0x04, core[2i]=0x00) -> codeword 0x8117: low byte 0x17, high byte 0x81.
- Junk upper bits: core[2i+1]=0xFF, core[2i]=0xFF -> same result as d=0x7FF, codeword 0xFFFF.
- 15 random 11-bit messages -> all 15 outputs match hamming_enc; done within 62 cycles of reset release; source bytes core[0..29] unchanged.
- Reset reasserted at cycle 20 of processing -> done=0 immediately; after release, final outputs are correct and done is reasserted.
